// File: rtl/imm_extend_stage.sv
// ============================================================================
//  Module      : imm_extend_stage
//  Description : RISC-V immediate extraction/extension stage with
//                valid/ready handshaking, optional 2-entry skid buffer and
//                a saturating counter of accepted illegal immediates.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_extend_stage #(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 1,
  parameter int SKID        = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic            out_illegal,
  output logic [31:0]     out_instr,
  input  logic            cnt_clr,
  output logic [7:0]      illegal_cnt
);

  // Payload layout: {imm, type, illegal, instr}
  localparam int PW = XLEN + 36;

  localparam logic [2:0] TYPE_I   = 3'd0;
  localparam logic [2:0] TYPE_S   = 3'd1;
  localparam logic [2:0] TYPE_B   = 3'd2;
  localparam logic [2:0] TYPE_J   = 3'd3;
  localparam logic [2:0] TYPE_U   = 3'd4;
  localparam logic [2:0] TYPE_Z   = 3'd5;
  localparam logic [2:0] TYPE_ILL = 3'd7;

  logic [2:0]      w_type;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  logic [PW-1:0]   w_entry;
  logic            w_in_ready;
  logic            w_out_valid;
  logic [PW-1:0]   w_head;
  logic            w_accept;
  logic            w_drain;
  logic [7:0]      cnt_q;
  logic [7:0]      cnt_d;

  // Resolve the immediate type from the opcode or from the explicit selector
  always_comb begin
    w_type = TYPE_ILL;
    if (AUTO_DECODE != 0) begin
      case (in_instr[6:0])
        7'b0010011,
        7'b0000011,
        7'b1100111: w_type = TYPE_I;
        7'b0011011: w_type = (XLEN == 64) ? TYPE_I : TYPE_ILL;
        7'b0100011: w_type = TYPE_S;
        7'b1100011: w_type = TYPE_B;
        7'b1101111: w_type = TYPE_J;
        7'b0110111,
        7'b0010111: w_type = TYPE_U;
        7'b1110011: w_type = in_instr[14] ? TYPE_Z : TYPE_I;
        default:    w_type = TYPE_ILL;
      endcase
    end else begin
      w_type = in_imm_src;
    end
  end

  // Extract and extend the immediate for the resolved type
  always_comb begin
    w_imm = '0;
    case (w_type)
      TYPE_I: w_imm = XLEN'($signed(in_instr[31:20]));
      TYPE_S: w_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      TYPE_B: w_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                     in_instr[11:8], 1'b0}));
      TYPE_J: w_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                     in_instr[30:21], 1'b0}));
      TYPE_U: w_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      TYPE_Z: w_imm = XLEN'(in_instr[19:15]);
      default: w_imm = '0;
    endcase
  end

  // Codes 110 and 111 are the unsupported types
  assign w_illegal = w_type[2] & w_type[1];
  assign w_entry   = {w_imm, w_type, w_illegal, in_instr};

  assign w_accept  = in_valid & w_in_ready;
  assign w_drain   = w_out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      localparam logic [1:0] ST_EMPTY = 2'd0;
      localparam logic [1:0] ST_ONE   = 2'd1;
      localparam logic [1:0] ST_TWO   = 2'd2;

      logic [1:0]    state_q, state_d;
      logic [PW-1:0] head_q, head_d;
      logic [PW-1:0] spare_q, spare_d;
      logic          in_ready_q, in_ready_d;

      // Skid buffer occupancy: head is the visible entry, spare catches the
      // input that arrives while the head is stalled
      always_comb begin
        state_d = state_q;
        head_d  = head_q;
        spare_d = spare_q;
        case (state_q)
          ST_EMPTY: begin
            if (w_accept) begin
              head_d  = w_entry;
              state_d = ST_ONE;
            end
          end
          ST_ONE: begin
            case ({w_accept, w_drain})
              2'b10: begin
                spare_d = w_entry;
                state_d = ST_TWO;
              end
              2'b01: state_d = ST_EMPTY;
              2'b11: head_d  = w_entry;
              default: state_d = ST_ONE;
            endcase
          end
          ST_TWO: begin
            if (w_drain) begin
              head_d  = spare_q;
              state_d = ST_ONE;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
        // Ready is registered so it never depends on out_ready combinationally
        in_ready_d = (state_d != ST_TWO);
      end

      // Skid buffer state registers
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q    <= ST_EMPTY;
          head_q     <= '0;
          spare_q    <= '0;
          in_ready_q <= 1'b0;
        end else begin
          state_q    <= state_d;
          head_q     <= head_d;
          spare_q    <= spare_d;
          in_ready_q <= in_ready_d;
        end
      end

      assign w_in_ready  = in_ready_q;
      assign w_out_valid = (state_q != ST_EMPTY);
      assign w_head      = head_q;
    end else begin : g_pipe
      logic          valid_q, valid_d;
      logic [PW-1:0] head_q, head_d;
      logic          run_q, run_d;

      // Single pipeline register; run_q holds ready low until the first
      // edge after reset release
      always_comb begin
        head_d  = head_q;
        valid_d = valid_q;
        run_d   = 1'b1;
        if (w_accept) begin
          head_d  = w_entry;
          valid_d = 1'b1;
        end else if (w_drain) begin
          valid_d = 1'b0;
        end
      end

      // Pipeline register state
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          head_q  <= '0;
          run_q   <= 1'b0;
        end else begin
          valid_q <= valid_d;
          head_q  <= head_d;
          run_q   <= run_d;
        end
      end

      assign w_in_ready  = run_q & (~valid_q | out_ready);
      assign w_out_valid = valid_q;
      assign w_head      = head_q;
    end
  endgenerate

  // Saturating illegal counter; clear dominates a coincident increment
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = 8'd0;
    end else if (w_accept && w_illegal && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Illegal counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  assign {out_imm, out_type, out_illegal, out_instr} = w_head;
  assign illegal_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_extend_stage.sv
// ============================================================================
//  Module      : tb_imm_extend_stage
//  Description : Self-checking bench for imm_extend_stage. Two instances
//                (XLEN=32 with skid buffer, XLEN=64 without) share stimulus
//                and are compared against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_extend_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        cnt_clr;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_src = 3'd0;

  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic [31:0] out_imm_a, out_instr_a;
  logic [2:0]  out_type_a;
  logic [7:0]  illegal_cnt_a;

  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [63:0] out_imm_b;
  logic [31:0] out_instr_b;
  logic [2:0]  out_type_b;
  logic [7:0]  illegal_cnt_b;

  always #5 clk = ~clk;

  imm_extend_stage u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_imm(out_imm_a), .out_type(out_type_a),
    .out_illegal(out_illegal_a), .out_instr(out_instr_a), .cnt_clr(cnt_clr),
    .illegal_cnt(illegal_cnt_a)
  );

  imm_extend_stage #(.XLEN(64), .AUTO_DECODE(1), .SKID(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_imm(out_imm_b), .out_type(out_type_b),
    .out_illegal(out_illegal_b), .out_instr(out_instr_b), .cnt_clr(cnt_clr),
    .illegal_cnt(illegal_cnt_b)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference: immediate type from the opcode table
  function automatic logic [2:0] ref_type(input logic [31:0] ins, input bit x64);
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: return 3'd0;
      7'h1B:               return x64 ? 3'd0 : 3'd7;
      7'h23:               return 3'd1;
      7'h63:               return 3'd2;
      7'h6F:               return 3'd3;
      7'h37, 7'h17:        return 3'd4;
      7'h73:               return ins[14] ? 3'd5 : 3'd0;
      default:             return 3'd7;
    endcase
  endfunction

  // Reference: immediate value by plain two's-complement arithmetic
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input bit x64);
    longint v;
    logic [2:0] t;
    t = ref_type(ins, x64);
    v = 0;
    case (t)
      3'd0: begin
        v = longint'(ins[31:20]);
        if (v >= 2048) v = v - 4096;
      end
      3'd1: begin
        v = longint'({ins[31:25], ins[11:7]});
        if (v >= 2048) v = v - 4096;
      end
      3'd2: begin
        v = longint'({ins[31], ins[7], ins[30:25], ins[11:8]});
        if (v >= 2048) v = v - 4096;
        v = v * 2;
      end
      3'd3: begin
        v = longint'({ins[31], ins[19:12], ins[20], ins[30:21]});
        if (v >= 524288) v = v - 1048576;
        v = v * 2;
      end
      3'd4: begin
        v = longint'(ins[31:12]);
        if (v >= 524288) v = v - 1048576;
        v = v * 4096;
      end
      3'd5: v = longint'(ins[19:15]);
      default: v = 0;
    endcase
    return x64 ? 64'(v) : (64'(v) & 64'h0000_0000_FFFF_FFFF);
  endfunction

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          cnt_a = 0;
  int          cnt_b = 0;
  logic        live  = 1'b0;

  // Ready may only rise one edge after reset release
  always @(posedge clk) live <= rst_n;

  // Compare process: check outputs, then advance the model for the coming edge
  always @(negedge clk) begin
    logic [31:0] e;
    bit acc, drn;
    if (!rst_n) begin
      chk("rst_valid_a", {63'd0, out_valid_a}, 64'd0);
      chk("rst_ready_a", {63'd0, in_ready_a}, 64'd0);
      chk("rst_cnt_a", {56'd0, illegal_cnt_a}, 64'd0);
      chk("rst_valid_b", {63'd0, out_valid_b}, 64'd0);
      chk("rst_ready_b", {63'd0, in_ready_b}, 64'd0);
      qa.delete();
      qb.delete();
      cnt_a = 0;
      cnt_b = 0;
    end else begin
      // 32-bit skid instance
      chk("ready_a", {63'd0, in_ready_a}, {63'd0, live && (qa.size() < 2)});
      chk("valid_a", {63'd0, out_valid_a}, {63'd0, qa.size() != 0});
      if (qa.size() != 0 && out_valid_a) begin
        e = qa[0];
        chk("imm_a", {32'd0, out_imm_a}, ref_imm(e, 1'b0));
        chk("type_a", {61'd0, out_type_a}, {61'd0, ref_type(e, 1'b0)});
        chk("ill_a", {63'd0, out_illegal_a}, {63'd0, ref_type(e, 1'b0) >= 3'd6});
        chk("instr_a", {32'd0, out_instr_a}, {32'd0, e});
      end
      chk("cnt_a", {56'd0, illegal_cnt_a}, 64'(cnt_a));
      acc = in_valid && in_ready_a;
      drn = out_valid_a && out_ready;
      if (drn && qa.size() != 0) void'(qa.pop_front());
      if (acc) qa.push_back(in_instr);
      if (cnt_clr) cnt_a = 0;
      else if (acc && ref_type(in_instr, 1'b0) >= 3'd6 && cnt_a < 255) cnt_a++;

      // 64-bit single-register instance
      chk("ready_b", {63'd0, in_ready_b},
          {63'd0, live && (qb.size() == 0 || out_ready)});
      chk("valid_b", {63'd0, out_valid_b}, {63'd0, qb.size() != 0});
      if (qb.size() != 0 && out_valid_b) begin
        e = qb[0];
        chk("imm_b", out_imm_b, ref_imm(e, 1'b1));
        chk("type_b", {61'd0, out_type_b}, {61'd0, ref_type(e, 1'b1)});
        chk("ill_b", {63'd0, out_illegal_b}, {63'd0, ref_type(e, 1'b1) >= 3'd6});
        chk("instr_b", {32'd0, out_instr_b}, {32'd0, e});
      end
      chk("cnt_b", {56'd0, illegal_cnt_b}, 64'(cnt_b));
      acc = in_valid && in_ready_b;
      drn = out_valid_b && out_ready;
      if (drn && qb.size() != 0) void'(qb.pop_front());
      if (acc) qb.push_back(in_instr);
      if (cnt_clr) cnt_b = 0;
      else if (acc && ref_type(in_instr, 1'b1) >= 3'd6 && cnt_b < 255) cnt_b++;
    end
  end

  // One instruction into empty stages, then literal checks one cycle later
  task automatic directed(input string nm, input logic [31:0] ins,
                          input logic [63:0] ea, input logic [2:0] ta,
                          input logic [63:0] eb, input logic [2:0] tb);
    in_valid  = 1'b1;
    in_instr  = ins;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({nm, "_va"}, {63'd0, out_valid_a}, 64'd1);
    chk({nm, "_imm_a"}, {32'd0, out_imm_a}, ea);
    chk({nm, "_type_a"}, {61'd0, out_type_a}, {61'd0, ta});
    chk({nm, "_ill_a"}, {63'd0, out_illegal_a}, {63'd0, ta >= 3'd6});
    chk({nm, "_imm_b"}, out_imm_b, eb);
    chk({nm, "_type_b"}, {61'd0, out_type_b}, {61'd0, tb});
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63,
            7'h6F, 7'h37, 7'h17, 7'h73, 7'h7F, 7'h33};
    r = $urandom;
    if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 11)];
    return r;
  endfunction

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    in_instr  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {63'd0, in_ready_a}, 64'd0);
    chk("reset_imm", {32'd0, out_imm_a}, 64'd0);
    chk("reset_type", {61'd0, out_type_a}, 64'd0);
    chk("reset_instr", {32'd0, out_instr_a}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", {63'd0, in_ready_a}, 64'd0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", {63'd0, in_ready_a}, 64'd1);

    // Pin the reference model against hand-computed values
    chk("pin_addi", ref_imm(32'hFFF00093, 1'b0), 64'h0000_0000_FFFF_FFFF);
    chk("pin_beq", ref_imm(32'hFE000EE3, 1'b0), 64'h0000_0000_FFFF_FFFC);
    chk("pin_lui64", ref_imm(32'h800002B7, 1'b1), 64'hFFFF_FFFF_8000_0000);
    chk("pin_csrrwi", ref_imm(32'h7C0FD073, 1'b0), 64'h0000_0000_0000_001F);

    directed("addi", 32'hFFF00093, 64'hFFFF_FFFF, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0);
    directed("beq", 32'hFE000EE3, 64'hFFFF_FFFC, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2);
    directed("lui", 32'h800002B7, 64'h8000_0000, 3'd4, 64'hFFFF_FFFF_8000_0000, 3'd4);
    directed("csrrwi", 32'h7C0FD073, 64'h1F, 3'd5, 64'h1F, 3'd5);
    directed("addiw", 32'h0010009B, 64'h0, 3'd7, 64'h1, 3'd0);
    directed("jal", 32'h8000006F, 64'hFFF0_0000, 3'd3, 64'hFFFF_FFFF_FFF0_0000, 3'd3);
    directed("sw", 32'hFE112E23, 64'hFFFF_FFFC, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1);
    @(posedge clk);
    #1;

    // Stall with three back-to-back inputs
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    @(posedge clk);
    #1;
    in_instr = 32'h00200093;
    @(posedge clk);
    #1;
    chk("full_ready", {63'd0, in_ready_a}, 64'd0);
    in_instr = 32'h00300093;
    repeat (2) @(posedge clk);
    #1;
    chk("full_ready_hold", {63'd0, in_ready_a}, 64'd0);
    chk("stall_head", {32'd0, out_instr_a}, 64'h00100093);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("order_second", {32'd0, out_instr_a}, 64'h00200093);
    n = 0;
    while (!in_ready_a && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("third_ready_timeout", {63'd0, in_ready_a}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("order_third", {32'd0, out_instr_a}, 64'h00300093);
    repeat (3) @(posedge clk);
    #1;

    // Saturation of the illegal counter
    in_valid = 1'b1;
    in_instr = 32'h0000007F;
    repeat (300) @(posedge clk);
    #1;
    chk("sat_cnt", {56'd0, illegal_cnt_a}, 64'd255);
    chk("sat_ill", {63'd0, out_illegal_a}, 64'd1);
    chk("sat_imm", {32'd0, out_imm_a}, 64'd0);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("clr_cnt", {56'd0, illegal_cnt_a}, 64'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset with two entries buffered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00500113;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pre_rst_valid", {63'd0, out_valid_a}, 64'd1);
    chk("pre_rst_full", {63'd0, in_ready_a}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, out_valid_a}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      in_instr  = rand_instr();
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    cnt_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drained_a", {63'd0, out_valid_a}, 64'd0);
    chk("drained_b", {63'd0, out_valid_b}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imm_extend_stage.md
IMM_EXTEND_STAGE -- requirements
Module: imm_extend_stage

Interface
- REQ-001 SHALL have parameter XLEN, default 32, meaning the immediate output width; legal values are 32 and 64 only.
- REQ-002 SHALL have parameter AUTO_DECODE, default 1, meaning the immediate type is derived from the opcode when 1 and taken from in_imm_src when 0.
- REQ-003 SHALL have parameter SKID, default 1, meaning a 2-entry skid buffer with registered in_ready when 1 and a single pipeline register when 0.
- REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-006 SHALL have port in_valid, input, 1 bit: the input instruction is valid.
- REQ-007 SHALL have port in_ready, output, 1 bit: the stage can accept an input.
- REQ-008 SHALL have port in_instr, input, 32 bits: the raw instruction word.
- REQ-009 SHALL have port in_imm_src, input, 3 bits: the explicit immediate type, used only when AUTO_DECODE=0.
- REQ-010 SHALL have port out_valid, output, 1 bit: the output payload is valid.
- REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the output.
- REQ-012 SHALL have port out_imm, output, XLEN bits: the extended immediate.
- REQ-013 SHALL have port out_type, output, 3 bits: the resolved immediate type.
- REQ-014 SHALL have port out_illegal, output, 1 bit: the resolved type is unsupported.
- REQ-015 SHALL have port out_instr, output, 32 bits: the instruction passed through unchanged.
- REQ-016 SHALL have port cnt_clr, input, 1 bit: synchronous clear of illegal_cnt.
- REQ-017 SHALL have port illegal_cnt, output, 8 bits: saturating count of accepted illegal inputs.

Function
- REQ-018 Type encoding SHALL be: 000 I = sext(instr[31:20]); 001 S = sext({instr[31:25],instr[11:7]}); 010 B = sext({instr[31],instr[7],instr[30:25],instr[11:8],0}); 011 J = sext({instr[31],instr[19:12],instr[20],instr[30:21],0}); 100 U = sext({instr[31:12],12'b0}); 101 Z = zext(instr[19:15]); 110/111 illegal, with imm 0 and out_illegal=1.
- REQ-019 Sign extension SHALL replicate the stated sign bit up to XLEN; for U-type with XLEN=64, bits 63:32 SHALL equal instr[31].
- REQ-020 AUTO_DECODE=1 SHALL map opcodes as follows: 0010011, 0000011 and 1100111 to I; 0011011 to I only when XLEN=64, otherwise illegal; 0100011 to S; 1100011 to B; 1101111 to J; 0110111 and 0010111 to U; 1110011 to Z when instr[14]=1 and to I when instr[14]=0; every other opcode to 111 (illegal).
- REQ-021 A transfer SHALL occur on an edge where valid&ready are both high; extension SHALL be computed at input acceptance and registered, so payload is valid 1 cycle after acceptance into an empty stage.
- REQ-022 While out_valid=1 and out_ready=0, out_imm, out_type, out_illegal and out_instr SHALL be held stable.
- REQ-023 Outputs SHALL leave in acceptance order, with no loss or duplication.
- REQ-024 SKID=0: in_ready SHALL equal !out_valid | out_ready (combinational).
- REQ-025 SKID=1: states EMPTY, ONE and TWO; in_ready SHALL be a register equal to (state != TWO).
- REQ-026 SKID=1 transitions: EMPTY->ONE on accept; ONE->TWO on accept without drain; ONE->EMPTY on drain without accept; ONE->ONE on simultaneous accept and drain; TWO->ONE on drain.
- REQ-027 SKID=1 SHALL sustain 1 transfer/cycle when out_ready is held high.
- REQ-028 illegal_cnt SHALL increment by 1 per accepted illegal input and saturate at 255.
- REQ-029 cnt_clr SHALL win over a simultaneous increment, giving illegal_cnt=0.

Reset
- REQ-030 While rst_n=0: out_valid=0; out_imm, out_type, out_illegal and out_instr = 0; illegal_cnt=0; skid state EMPTY; in_ready=0.
- REQ-031 The first edge after rst_n rises SHALL set in_ready=1.
- REQ-032 Reset asserted mid-operation SHALL discard all buffered entries immediately.

Verification
- REQ-033 addi x1,x0,-1 (0xFFF00093), AUTO -> next cycle out_imm=0xFFFFFFFF, out_type=000, out_illegal=0.
- REQ-034 beq, offset -4 (0xFE000EE3) -> out_imm=0xFFFFFFFC, out_type=010.
- REQ-035 XLEN=64, lui x5,0x80000 (0x800002B7) -> out_imm=0xFFFFFFFF80000000, out_type=100.
- REQ-036 csrrwi (0x7C0FD073) -> out_imm=0x0000001F, out_type=101.
- REQ-037 SKID=1, 3 back-to-back inputs with out_ready=0 -> in_ready=0 after 2 accepts; on out_ready=1 outputs emerge in order, then the third input is accepted.
- REQ-038 300 inputs of 0x0000007F -> out_illegal=1, out_imm=0, illegal_cnt=255; cnt_clr asserted with an illegal input -> illegal_cnt=0; rst_n pulse with TWO entries buffered -> out_valid=0 immediately.
